// File: rtl/chol_pkg.sv
// chol_pkg: shared constants, state encoding and the saturating Q16.16 multiply
//   FRAC_BITS       - fractional bits of the Q16.16 format
//   Q_MAX / Q_MIN   - saturation limits
//   MUL_LATENCY_DEF - default multiplier pipeline depth
//   state_t         - one-hot column-scaler states
//   q_mul()         - signed Q16.16 product, floor-truncated, saturated
package chol_pkg;
    localparam int FRAC_BITS = 16;
    localparam logic [31:0] Q_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] Q_MIN = 32'h8000_0000;
    localparam int MUL_LATENCY_DEF = 7;
    typedef enum logic [5:0] {
        S_IDLE     = 6'b000001,
        S_REQ      = 6'b000010,
        S_WAIT_INV = 6'b000100,
        S_STREAM   = 6'b001000,
        S_DRAIN    = 6'b010000,
        S_DONE     = 6'b100000
    } state_t;
    // Keeps product[47:16]; bits above that must all match the kept sign bit,
    // otherwise the result clips toward the product's sign.
    function automatic logic [31:0] q_mul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ax, bx, p;
        ax = {{32{a[31]}}, a};
        bx = {{32{b[31]}}, b};
        p = ax * bx;
        q_mul = (&p[63:FRAC_BITS+31] | ~|p[63:FRAC_BITS+31]) ? p[FRAC_BITS+31:FRAC_BITS]
              : (p[63] ? Q_MIN : Q_MAX);
    endfunction
endpackage

// File: rtl/chol_col_scale_if.sv
// chol_col_scale_if: column-scaler bus bundling request, inverse-sqrt, element and result channels
//   master: column source / inverse-sqrt unit / result sink side
//   slave : chol_col_scale side
interface chol_col_scale_if #(parameter int N_W = 5);
    logic             start;
    logic [31:0]      diag;
    logic [N_W-1:0]   n_elems;
    logic             sqrt_req;
    logic [31:0]      sqrt_data;
    logic [31:0]      inv_sqrt;
    logic             inv_sqrt_valid;
    logic [31:0]      elem;
    logic             elem_valid;
    logic             elem_ready;
    logic [31:0]      out;
    logic             out_valid;
    logic             out_diag;
    logic [N_W-1:0]   out_idx;
    logic             busy;
    logic             done;
    modport master (
        output start, diag, n_elems, inv_sqrt, inv_sqrt_valid, elem, elem_valid,
        input  sqrt_req, sqrt_data, elem_ready, out, out_valid, out_diag, out_idx, busy, done
    );
    modport slave (
        input  start, diag, n_elems, inv_sqrt, inv_sqrt_valid, elem, elem_valid,
        output sqrt_req, sqrt_data, elem_ready, out, out_valid, out_diag, out_idx, busy, done
    );
endinterface

// File: rtl/chol_mult_pipe.sv
// chol_mult_pipe: pipelined saturating Q16.16 multiplier with valid/tag shift register
//   clk, rst, clken       - clock, sync active-high reset, global enable (freezes everything)
//   in_valid, a, b        - operands, registered on the issuing edge
//   in_diag, in_idx       - tags carried alongside the product
//   out_valid, out        - result, MUL_LATENCY enabled cycles after the issuing edge
//   out_diag, out_idx     - tags aligned with out
//   busy                  - any stage holds a valid entry
module chol_mult_pipe
    import chol_pkg::*;
#(
    parameter int N_W = 5,
    parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clken,
    input  logic             in_valid,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  logic             in_diag,
    input  logic [N_W-1:0]   in_idx,
    output logic             out_valid,
    output logic [31:0]      out,
    output logic             out_diag,
    output logic [N_W-1:0]   out_idx,
    output logic             busy
);
    // Stage 0 is the operand register; the product is formed from it into
    // res[1] and then delayed so res[MUL_LATENCY] lines up with vld[MUL_LATENCY].
    logic [31:0]          a_q, b_q;
    logic [MUL_LATENCY:0] vld, dg;
    logic [N_W-1:0]       ix [0:MUL_LATENCY];
    logic [31:0]          res [1:MUL_LATENCY];
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            vld <= '0;
            dg  <= '0;
            for (int k = 0; k <= MUL_LATENCY; k++) ix[k] <= '0;
            for (int k = 1; k <= MUL_LATENCY; k++) res[k] <= '0;
        end else if (clken) begin
            a_q <= a;
            b_q <= b;
            vld <= {vld[MUL_LATENCY-1:0], in_valid};
            dg  <= {dg[MUL_LATENCY-1:0], in_diag};
            ix[0] <= in_idx;
            res[1] <= q_mul(a_q, b_q);
            for (int k = 1; k <= MUL_LATENCY; k++) ix[k] <= ix[k-1];
            for (int k = 2; k <= MUL_LATENCY; k++) res[k] <= res[k-1];
        end
    end
    assign out_valid = vld[MUL_LATENCY];
    assign out       = res[MUL_LATENCY];
    assign out_diag  = dg[MUL_LATENCY];
    assign out_idx   = ix[MUL_LATENCY];
    assign busy      = |vld;
endmodule

// File: rtl/chol_col_scale.sv
// chol_col_scale: scales a Cholesky column by 1/sqrt(A[j][j]) obtained from chol_inv_sqrt
//   clk, rst   - clock, sync active-high reset (aborts any column in flight)
//   clken      - global enable; low freezes state, counters, pipe and outputs
//   bus.start/diag/n_elems            - column request, sampled only when idle
//   bus.sqrt_req/sqrt_data            - one-cycle request to chol_inv_sqrt
//   bus.inv_sqrt/inv_sqrt_valid       - level-valid reply from chol_inv_sqrt
//   bus.elem/elem_valid/elem_ready    - sub-diagonal element stream
//   bus.out/out_valid/out_diag/out_idx - results, diagonal first, in issue order
//   bus.busy/done                     - not idle / end-of-column pulse
module chol_col_scale
    import chol_pkg::*;
#(
    parameter int N_W = 5,
    parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clken,
    chol_col_scale_if.slave bus
);
    state_t         state, nxt;
    logic [31:0]    diag_q, inv_q, sqrt_data_q;
    logic [N_W-1:0] n_q, cnt;
    logic           inv_prev, inv_rise, accept, issue, tag_diag, pipe_busy;
    logic [31:0]    mul_a, mul_b;
    logic [N_W-1:0] tag_idx;
    // Only a fresh rising edge counts: the reply valid is a level that may
    // still be high from the previous column when this one starts waiting.
    assign inv_rise = bus.inv_sqrt_valid & ~inv_prev;
    assign accept   = (state == S_STREAM) & bus.elem_valid;
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else if (clken) state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:     if (bus.start) nxt = S_REQ;
            S_REQ:      nxt = S_WAIT_INV;
            S_WAIT_INV: if (inv_rise) nxt = (n_q == '0) ? S_DRAIN : S_STREAM;
            S_STREAM:   if (accept && cnt + N_W'(1) == n_q) nxt = S_DRAIN;
            S_DRAIN:    if (!pipe_busy) nxt = S_DONE;
            S_DONE:     nxt = S_IDLE;
            default:    nxt = S_IDLE;
        endcase
    end
    always_comb begin
        bus.sqrt_req   = state == S_REQ;
        bus.elem_ready = state == S_STREAM;
        bus.busy       = state != S_IDLE;
        bus.done       = state == S_DONE;
        // The diagonal product uses the reply directly on its capture cycle;
        // elements use the latched copy.
        issue    = ((state == S_WAIT_INV) & inv_rise) | accept;
        mul_a    = (state == S_STREAM) ? bus.elem : diag_q;
        mul_b    = (state == S_STREAM) ? inv_q : bus.inv_sqrt;
        tag_diag = state != S_STREAM;
        tag_idx  = (state == S_STREAM) ? cnt + N_W'(1) : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            diag_q      <= '0;
            inv_q       <= '0;
            sqrt_data_q <= '0;
            n_q         <= '0;
            cnt         <= '0;
            inv_prev    <= 1'b0;
        end else if (clken) begin
            inv_prev <= bus.inv_sqrt_valid;
            if (state == S_IDLE && bus.start) begin
                diag_q      <= bus.diag;
                n_q         <= bus.n_elems;
                sqrt_data_q <= bus.diag;
                cnt         <= '0;
            end
            if (state == S_WAIT_INV && inv_rise) inv_q <= bus.inv_sqrt;
            if (accept) cnt <= cnt + N_W'(1);
        end
    end
    assign bus.sqrt_data = sqrt_data_q;
    chol_mult_pipe #(.N_W(N_W), .MUL_LATENCY(MUL_LATENCY)) u_pipe (
        .clk(clk),
        .rst(rst),
        .clken(clken),
        .in_valid(issue),
        .a(mul_a),
        .b(mul_b),
        .in_diag(tag_diag),
        .in_idx(tag_idx),
        .out_valid(bus.out_valid),
        .out(bus.out),
        .out_diag(bus.out_diag),
        .out_idx(bus.out_idx),
        .busy(pipe_busy)
    );
endmodule

// File: tb/tb_chol_col_scale.sv
// tb_chol_col_scale: directed self-checking bench for chol_col_scale
module tb_chol_col_scale;
    localparam int L = 7;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clken = 1'b1;
    always #5 clk = ~clk;

    chol_col_scale_if #(.N_W(5)) bus();
    chol_col_scale #(.N_W(5), .MUL_LATENCY(L)) dut (
        .clk(clk),
        .rst(rst),
        .clken(clken),
        .bus(bus.slave)
    );

    typedef struct {
        logic [31:0] v;
        logic        d;
        logic [4:0]  i;
        int          c;
    } rec_t;

    rec_t outq[$];
    int   accq[$];
    int   cyc = 0;
    int   done_cnt = 0;
    int   er_cnt = 0;
    logic en_pend = 1'b0;
    rec_t r;
    int   checks = 0;
    int   errors = 0;

    // Inputs change only at posedge+1, so at the negedge every value is stable.
    // cyc counts enabled edges; a value is recorded once, on the first negedge
    // after the enabled edge that produced it.
    always @(negedge clk) begin
        if (en_pend) cyc++;
        if (en_pend && bus.out_valid === 1'b1) begin
            r.v = bus.out; r.d = bus.out_diag; r.i = bus.out_idx; r.c = cyc;
            outq.push_back(r);
        end
        if (en_pend && bus.done === 1'b1) done_cnt++;
        if (clken && !rst && bus.elem_valid && bus.elem_ready === 1'b1) accq.push_back(cyc + 1);
        if (bus.elem_ready === 1'b1) er_cnt++;
        en_pend = clken;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_col(input logic [31:0] d, input logic [4:0] n);
        bus.diag = d;
        bus.n_elems = n;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic give_inv(input logic [31:0] v);
        bus.inv_sqrt_valid = 1'b0;
        tick();
        bus.inv_sqrt = v;
        bus.inv_sqrt_valid = 1'b1;
        tick();
    endtask

    task automatic send_elem(input logic [31:0] e, output bit ok);
        bus.elem = e;
        bus.elem_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            ok = (bus.elem_ready === 1'b1) && clken;
            tick();
        end
        bus.elem_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0;
        d0 = done_cnt;
        ok = 1'b0;
        for (int t = 0; t < budget && !ok; t++) begin
            tick();
            ok = done_cnt > d0;
        end
    endtask

    task automatic run_col(input logic [31:0] d, input logic [4:0] n, input logic [31:0] inv,
                           input logic [31:0] es[$], output bit ok);
        bit a;
        ok = 1'b1;
        start_col(d, n);
        give_inv(inv);
        foreach (es[k]) begin
            send_elem(es[k], a);
            ok &= a;
        end
        wait_done(60, a);
        ok &= a;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.out_valid, bus.out_diag, bus.busy, bus.done, bus.elem_ready, bus.sqrt_req} !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 000000",
                     {bus.out_valid, bus.out_diag, bus.busy, bus.done, bus.elem_ready, bus.sqrt_req});
        end
        checks++;
        if (bus.out !== 32'h0 || bus.out_idx !== 5'd0) begin
            errors++;
            $display("FAIL reset_out: got %h/%0d want 0/0", bus.out, bus.out_idx);
        end
        checks++;
        if (bus.sqrt_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_sqrt_data: got %h want 0", bus.sqrt_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        int ob, ab;
        bit ok1, ok2, ok3;
        logic [31:0] ev[3];
        ev = '{32'h0002_0000, 32'h0000_8000, 32'hFFFF_0000};
        ob = outq.size();
        ab = accq.size();
        start_col(32'h0004_0000, 5'd2);
        checks++;
        if (bus.sqrt_req !== 1'b1 || bus.sqrt_data !== 32'h0004_0000 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL nominal_req: got req%b data %h busy%b want req1 data 00040000 busy1",
                     bus.sqrt_req, bus.sqrt_data, bus.busy);
        end
        give_inv(32'h0000_8000);
        checks++;
        if (bus.sqrt_req !== 1'b0) begin
            errors++;
            $display("FAIL nominal_req_pulse: got %b want 0", bus.sqrt_req);
        end
        send_elem(32'h0001_0000, ok1);
        send_elem(32'hFFFE_0000, ok2);
        checks++;
        if (!(ok1 && ok2) || bus.elem_ready !== 1'b0) begin
            errors++;
            $display("FAIL nominal_accept: got ok %b%b ready %b want ok 11 ready 0", ok1, ok2, bus.elem_ready);
        end
        wait_done(60, ok3);
        checks++;
        if (!ok3 || outq.size() - ob != 3) begin
            errors++;
            $display("FAIL nominal_count: got done %b results %0d want done 1 results 3", ok3, outq.size() - ob);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (outq[ob+k].v !== ev[k] || outq[ob+k].d !== (k == 0) || outq[ob+k].i !== 5'(k)) begin
                    errors++;
                    $display("FAIL nominal_out[%0d]: got %h d%b i%0d want %h d%b i%0d", k,
                             outq[ob+k].v, outq[ob+k].d, outq[ob+k].i, ev[k], k == 0, k);
                end
            end
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (outq[ob+k].c - accq[ab+k-1] != L) begin
                    errors++;
                    $display("FAIL nominal_latency[%0d]: got %0d want %0d", k, outq[ob+k].c - accq[ab+k-1], L);
                end
            end
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL nominal_idle: got busy %b want 0", bus.busy);
        end
    endtask

    task automatic test_stale();
        int ob;
        bit ok;
        bus.inv_sqrt = 32'h0000_8000;
        bus.inv_sqrt_valid = 1'b1;
        tick();
        ob = outq.size();
        start_col(32'h0004_0000, 5'd0);
        repeat (6) tick();
        checks++;
        if (outq.size() != ob || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL stale_no_capture: got results %0d busy %b want 0 busy 1", outq.size() - ob, bus.busy);
        end
        give_inv(32'h0001_0000);
        wait_done(60, ok);
        checks++;
        if (!ok || outq.size() - ob != 1) begin
            errors++;
            $display("FAIL stale_count: got done %b results %0d want 1 1", ok, outq.size() - ob);
        end else if (outq[ob].v !== 32'h0004_0000 || outq[ob].d !== 1'b1) begin
            errors++;
            $display("FAIL stale_value: got %h d%b want 00040000 d1", outq[ob].v, outq[ob].d);
        end
    endtask

    task automatic test_zero();
        int ob, eb;
        bit ok;
        logic [31:0] none[$];
        ob = outq.size();
        eb = er_cnt;
        run_col(32'h0009_0000, 5'd0, 32'h0000_5555, none, ok);
        checks++;
        if (!ok || outq.size() - ob != 1 || er_cnt != eb) begin
            errors++;
            $display("FAIL zero_shape: got done %b results %0d ready_cycles %0d want 1 1 0",
                     ok, outq.size() - ob, er_cnt - eb);
        end else begin
            checks++;
            if (outq[ob].v !== 32'h0002_FFFD || outq[ob].d !== 1'b1 || outq[ob].i !== 5'd0) begin
                errors++;
                $display("FAIL zero_value: got %h d%b i%0d want 0002fffd d1 i0", outq[ob].v, outq[ob].d, outq[ob].i);
            end
        end
    endtask

    task automatic test_sat();
        int ob;
        bit ok;
        logic [31:0] es[$];
        logic [31:0] ev[3];
        es = '{32'h7FFF_0000, 32'h8000_0000};
        ev = '{32'h0002_0000, 32'h7FFF_FFFF, 32'h8000_0000};
        ob = outq.size();
        run_col(32'h0001_0000, 5'd2, 32'h0002_0000, es, ok);
        checks++;
        if (!ok || outq.size() - ob != 3) begin
            errors++;
            $display("FAIL sat_count: got done %b results %0d want 1 3", ok, outq.size() - ob);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (outq[ob+k].v !== ev[k] || outq[ob+k].i !== 5'(k)) begin
                    errors++;
                    $display("FAIL sat_out[%0d]: got %h i%0d want %h i%0d", k, outq[ob+k].v, outq[ob+k].i, ev[k], k);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int ob, ab, k, d0;
        bit acc, ok;
        logic [31:0] es[5];
        es = '{32'h0001_1111, 32'h0002_2222, 32'hFFF3_3333, 32'h0004_4444, 32'h7005_5555};
        ob = outq.size();
        ab = accq.size();
        start_col(32'h0001_0000, 5'd5);
        give_inv(32'h0001_0000);
        k = 0;
        for (int t = 0; t < 100 && k < 5; t++) begin
            clken = (t % 3) != 1;
            bus.elem_valid = (t % 4) != 2;
            bus.elem = es[k];
            acc = clken && bus.elem_valid && (bus.elem_ready === 1'b1);
            tick();
            if (acc) k++;
        end
        bus.elem_valid = 1'b0;
        d0 = done_cnt;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            clken = (t % 2) == 0;
            tick();
            ok = done_cnt > d0;
        end
        clken = 1'b1;
        tick();
        checks++;
        if (k != 5 || !ok || outq.size() - ob != 6) begin
            errors++;
            $display("FAIL b2b_count: got accepted %0d done %b results %0d want 5 1 6", k, ok, outq.size() - ob);
        end else begin
            checks++;
            if (outq[ob].v !== 32'h0001_0000 || outq[ob].d !== 1'b1) begin
                errors++;
                $display("FAIL b2b_diag: got %h d%b want 00010000 d1", outq[ob].v, outq[ob].d);
            end
            for (int j = 0; j < 5; j++) begin
                checks++;
                if (outq[ob+j+1].v !== es[j] || outq[ob+j+1].d !== 1'b0 || outq[ob+j+1].i !== 5'(j + 1)
                    || outq[ob+j+1].c - accq[ab+j] != L) begin
                    errors++;
                    $display("FAIL b2b_out[%0d]: got %h d%b i%0d lat %0d want %h d0 i%0d lat %0d", j + 1,
                             outq[ob+j+1].v, outq[ob+j+1].d, outq[ob+j+1].i, outq[ob+j+1].c - accq[ab+j],
                             es[j], j + 1, L);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int ob;
        bit ok;
        logic [31:0] es[$];
        logic [31:0] ev[2];
        es = '{32'h0001_0000};
        ev = '{32'h0002_0000, 32'h0000_8000};
        start_col(32'h0001_0000, 5'd3);
        give_inv(32'h0001_0000);
        send_elem(32'h0003_0000, ok);
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.out_valid, bus.busy, bus.done, bus.elem_ready, bus.sqrt_req} !== 5'b0
            || bus.out !== 32'h0 || bus.sqrt_data !== 32'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got strobes %b out %h sqrt_data %h want 00000 0 0",
                     {bus.out_valid, bus.busy, bus.done, bus.elem_ready, bus.sqrt_req}, bus.out, bus.sqrt_data);
        end
        rst = 1'b0;
        ob = outq.size();
        repeat (12) tick();
        checks++;
        if (outq.size() != ob || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet: got results %0d busy %b want 0 0", outq.size() - ob, bus.busy);
        end
        run_col(32'h0004_0000, 5'd1, 32'h0000_8000, es, ok);
        checks++;
        if (!ok || outq.size() - ob != 2) begin
            errors++;
            $display("FAIL midreset_rerun: got done %b results %0d want 1 2", ok, outq.size() - ob);
        end else begin
            for (int j = 0; j < 2; j++) begin
                checks++;
                if (outq[ob+j].v !== ev[j] || outq[ob+j].i !== 5'(j)) begin
                    errors++;
                    $display("FAIL midreset_out[%0d]: got %h i%0d want %h i%0d", j, outq[ob+j].v, outq[ob+j].i, ev[j], j);
                end
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.diag = '0;
        bus.n_elems = '0;
        bus.inv_sqrt = '0;
        bus.inv_sqrt_valid = 1'b0;
        bus.elem = '0;
        bus.elem_valid = 1'b0;
        test_reset();
        test_nominal();
        test_stale();
        test_zero();
        test_sat();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
